// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
//
// Shares one external combinational ALU between two requesters. A three-state
// FSM (IDLE -> EXEC -> RESP) accepts one operation at a time. When both
// requesters ask at once, the grant goes round-robin against the last served
// requester. The operands are latched when the operation is accepted. The ALU
// result is captured in EXEC and held in RESP until the consumer takes it.
//
// Optional feature (macro ALU_OPCHECK_EN):
//   defined   - an accepted opcode outside {AND, OR, ADD, SUB} skips EXEC and
//               responds one cycle after accept with out_err = 1, out_z = 0,
//               out_ex = 0.
//   undefined - every opcode goes to the ALU unchecked and out_err is 0.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   in0_valid/in0_a/b/op       requester 0 operation request
//   in1_valid/in1_a/b/op       requester 1 operation request
//   in0_ready, in1_ready       grant strobes (combinational, IDLE only)
//   alu_a, alu_b, alu_op       drive the shared ALU from the operand registers
//   alu_z, alu_ex              ALU result and flag
//   out_valid, out_ready       result handshake
//   out_z, out_ex, out_id      result, flag and index of the requester served
//   out_err                    illegal-opcode flag
//   busy                       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_share_arb #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_a,
    input  logic [WIDTH-1:0] in0_b,
    input  logic [2:0]       in0_op,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_a,
    input  logic [WIDTH-1:0] in1_b,
    input  logic [2:0]       in1_op,
    output logic             in0_ready,
    output logic             in1_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_z,
    input  logic             alu_ex,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             out_ex,
    output logic             out_id,
    output logic             out_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] opr_a;
    logic [WIDTH-1:0] opr_b;
    logic [2:0]       opr_op;
    logic             opr_id;
    logic             last_grant;

    logic             grant_valid;
    logic             grant_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;
    logic             sel_illegal;

    // Grants are only issued from IDLE. On a tie the requester that was not
    // served last wins.
    // NOTE: every output of an always_comb gets a default first, so a path that
    // does not assign it cannot infer a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state == IDLE) begin
            if (in0_valid && in1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end else if (in0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (in1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign in0_ready = grant_valid && !grant_id;
    assign in1_ready = grant_valid &&  grant_id;

    assign sel_a  = grant_id ? in1_a  : in0_a;
    assign sel_b  = grant_id ? in1_b  : in0_b;
    assign sel_op = grant_id ? in1_op : in0_op;

`ifdef ALU_OPCHECK_EN
    assign sel_illegal = !(sel_op inside {3'b000, 3'b001, 3'b010, 3'b110});
`else
    assign sel_illegal = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = sel_illegal ? RESP : EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the values from before the edge, whatever the statement order.
    // NOTE: reset clears every register, the operand registers included. The
    // ALU inputs are then defined from the first cycle, not X.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            opr_a      <= '0;
            opr_b      <= '0;
            opr_op     <= '0;
            opr_id     <= 1'b0;
            last_grant <= 1'b1;     // requester 0 wins the first tie
            out_z      <= '0;
            out_ex     <= 1'b0;
            out_id     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        opr_a  <= sel_a;
                        opr_b  <= sel_b;
                        opr_op <= sel_op;
                        opr_id <= grant_id;
                        // A rejected opcode goes straight to RESP, so its
                        // response fields are loaded here instead of in EXEC.
                        if (sel_illegal) begin
                            out_z  <= '0;
                            out_ex <= 1'b0;
                            out_id <= grant_id;
                        end
                    end
                end
                EXEC: begin
                    out_z  <= alu_z;
                    out_ex <= alu_ex;
                    out_id <= opr_id;
                end
                RESP: begin
                    if (out_ready) last_grant <= out_id;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_OPCHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (grant_valid) begin
            err_q <= sel_illegal;
        end
    end

    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    assign alu_a     = opr_a;
    assign alu_b     = opr_b;
    assign alu_op    = opr_op;
    assign out_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arb
//
// Testbench for alu_share_arb with WIDTH = 32. A behavioural ALU answers the
// shared ALU port. Inputs change 1 ns after a rising edge and outputs are
// sampled on the falling edge. The bench applies:
//   - a table of single transactions, each started from reset
//   - hand-written sequences: tie followed by round-robin fairness,
//     backpressure, reset while in EXEC, and an undefined opcode
//   - randomized traffic checked against a transaction-level reference model
// Expectations for the undefined opcode follow ALU_OPCHECK_EN when it is
// defined for the build.
// -----------------------------------------------------------------------------
module tb_alu_share_arb;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in0_valid, in1_valid;
    logic [W-1:0] in0_a, in0_b, in1_a, in1_b;
    logic [2:0]   in0_op, in1_op;
    logic         in0_ready, in1_ready;
    logic [W-1:0] alu_a, alu_b, alu_z;
    logic [2:0]   alu_op;
    logic         alu_ex;
    logic         out_valid, out_ready;
    logic [W-1:0] out_z;
    logic         out_ex, out_id, out_err, busy;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_share_arb #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in0_valid(in0_valid), .in0_a(in0_a), .in0_b(in0_b), .in0_op(in0_op),
        .in1_valid(in1_valid), .in1_a(in1_a), .in1_b(in1_b), .in1_op(in1_op),
        .in0_ready(in0_ready), .in1_ready(in1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_z(alu_z), .alu_ex(alu_ex),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_ex(out_ex), .out_id(out_id), .out_err(out_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: ex is the carry for ADD and the borrow for SUB.
    // Undefined opcodes return a ^ b with ex = 1 so they are easy to spot.
    function automatic void ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [2:0] op,
                                    output logic [W-1:0] z, output logic ex);
        logic [W:0] wide;
        case (op)
            3'b000: begin z = a & b; ex = 1'b0; end
            3'b001: begin z = a | b; ex = 1'b0; end
            3'b010: begin wide = {1'b0, a} + {1'b0, b}; z = wide[W-1:0]; ex = wide[W]; end
            3'b110: begin z = a - b; ex = (a < b); end
            default: begin z = a ^ b; ex = 1'b1; end
        endcase
    endfunction

    always_comb ref_alu(alu_a, alu_b, alu_op, alu_z, alu_ex);

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        in0_valid = 1'b0; in0_a = '0; in0_b = '0; in0_op = '0;
        in1_valid = 1'b0; in1_a = '0; in1_b = '0; in1_op = '0;
        out_ready = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Moves from the falling-edge sample point to 1 ns after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         v0, v1;
        logic [W-1:0] a0, b0;
        logic [2:0]   op0;
        logic [W-1:0] a1, b1;
        logic [2:0]   op1;
        logic         r0, r1;
        logic [W-1:0] z;
        logic         ex;
        logic         id;
    } vec_t;

    vec_t vecs[5];

    // Reference model state for the randomized run.
    logic         m_inflight;
    int           m_age;
    logic         m_last;
    logic [W-1:0] m_z;
    logic         m_ex;
    logic         m_id;
    logic         pend0, pend1;

    initial begin
        logic [W-1:0] zs[6];
        logic         ids[6];
        int           n;

        vecs[0] = '{1'b1, 1'b0, 32'd5, 32'd3, 3'b010, 32'd0, 32'd0, 3'b000,
                    1'b1, 1'b0, 32'd8, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'd0, 32'd0, 3'b000, 32'h0000_F0F0, 32'h0000_0FF0, 3'b001,
                    1'b0, 1'b1, 32'h0000_FFF0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 32'd3, 32'd5, 3'b000, 32'd3, 32'd5, 3'b110,
                    1'b1, 1'b0, 32'd1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'd0, 32'd0, 3'b000, 32'd3, 32'd5, 3'b110,
                    1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 3'b010, 32'd0, 32'd0, 3'b000,
                    1'b1, 1'b0, 32'd0, 1'b1, 1'b0};

        // ---------------- reset state ----------------
        do_reset();
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy",      busy, 0);
        check("rst_out_z",     out_z, 0);
        check("rst_out_ex",    out_ex, 0);
        check("rst_out_id",    out_id, 0);
        check("rst_out_err",   out_err, 0);
        check("rst_in0_ready", in0_ready, 0);
        check("rst_in1_ready", in1_ready, 0);
        check("rst_alu_a",     alu_a, 0);
        check("rst_alu_b",     alu_b, 0);
        check("rst_alu_op",    alu_op, 0);

        // ---------------- table of single transactions ----------------
        for (int i = 0; i < 5; i++) begin
            do_reset();
            in0_valid = vecs[i].v0; in0_a = vecs[i].a0; in0_b = vecs[i].b0; in0_op = vecs[i].op0;
            in1_valid = vecs[i].v1; in1_a = vecs[i].a1; in1_b = vecs[i].b1; in1_op = vecs[i].op1;
            @(negedge clk);                               // cycle N
            check($sformatf("v%0d_in0_ready", i), in0_ready, vecs[i].r0);
            check($sformatf("v%0d_in1_ready", i), in1_ready, vecs[i].r1);
            next_cycle();
            in0_valid = 1'b0; in1_valid = 1'b0;
            @(negedge clk);                               // N+1, EXEC
            check($sformatf("v%0d_exec_out_valid", i), out_valid, 0);
            check($sformatf("v%0d_exec_busy", i), busy, 1);
            next_cycle();
            @(negedge clk);                               // N+2, RESP
            check($sformatf("v%0d_out_valid", i), out_valid, 1);
            check($sformatf("v%0d_out_z", i), out_z, vecs[i].z);
            check($sformatf("v%0d_out_ex", i), out_ex, vecs[i].ex);
            check($sformatf("v%0d_out_id", i), out_id, vecs[i].id);
            check($sformatf("v%0d_out_err", i), out_err, 0);
            next_cycle();
            @(negedge clk);
            check($sformatf("v%0d_idle_busy", i), busy, 0);
        end

        // ---------------- tie then fairness: ids 0,1,0,1,0,1 ----------------
        do_reset();
        in0_valid = 1'b1; in0_a = 32'd3; in0_b = 32'd5; in0_op = 3'b000;
        in1_valid = 1'b1; in1_a = 32'd3; in1_b = 32'd5; in1_op = 3'b110;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                zs[n] = out_z; ids[n] = out_id; n++;
            end
            next_cycle();
        end
        check("fair_count", n, 6);
        for (int i = 0; i < n; i++) begin
            check($sformatf("fair_id%0d", i), ids[i], i % 2);
            check($sformatf("fair_z%0d", i), zs[i], (i % 2 == 0) ? 32'd1 : 32'hFFFF_FFFE);
        end

        // ---------------- backpressure ----------------
        do_reset();
        in0_valid = 1'b1; in0_a = 32'd7; in0_b = 32'd9; in0_op = 3'b010;
        @(negedge clk);
        check("bp_accept", in0_ready, 1);
        next_cycle();
        out_ready = 1'b0;
        in1_valid = 1'b1; in1_a = 32'd1; in1_b = 32'd2; in1_op = 3'b010;   // waits
        @(negedge clk);                                   // EXEC
        check("bp_exec_in1_ready", in1_ready, 0);
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d_out_valid", k), out_valid, 1);
            check($sformatf("bp%0d_out_z", k), out_z, 32'd16);
            check($sformatf("bp%0d_in0_ready", k), in0_ready, 0);
            check($sformatf("bp%0d_in1_ready", k), in1_ready, 0);
            check($sformatf("bp%0d_busy", k), busy, 1);
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_done_out_valid", out_valid, 1);
        check("bp_done_out_z", out_z, 32'd16);
        next_cycle();
        @(negedge clk);
        check("bp_after_busy", busy, 0);
        check("bp_after_in1_ready", in1_ready, 1);      // round-robin after id 0
        check("bp_after_in0_ready", in0_ready, 0);

        // ---------------- reset during EXEC ----------------
        do_reset();
        in0_valid = 1'b1; in0_a = 32'd11; in0_b = 32'd4; in0_op = 3'b010;
        @(negedge clk);
        check("rx_accept", in0_ready, 1);
        next_cycle();
        in0_valid = 1'b0;
        reset = 1'b1;                                     // asserted while in EXEC
        @(negedge clk);
        check("rx_in_exec_busy", busy, 1);
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rx%0d_out_valid", k), out_valid, 0);
            check($sformatf("rx%0d_busy", k), busy, 0);
            next_cycle();
        end

        // ---------------- undefined opcode 011 from requester 1 ----------------
        do_reset();
        in1_valid = 1'b1; in1_a = 32'd6; in1_b = 32'd3; in1_op = 3'b011;
        @(negedge clk);
        check("op3_accept", in1_ready, 1);
        next_cycle();
        in1_valid = 1'b0;
        @(negedge clk);                                   // N+1
`ifdef ALU_OPCHECK_EN
        check("op3_out_valid", out_valid, 1);
        check("op3_out_err",   out_err, 1);
        check("op3_out_z",     out_z, 0);
        check("op3_out_ex",    out_ex, 0);
        check("op3_out_id",    out_id, 1);
        next_cycle();
`else
        check("op3_alu_op",    alu_op, 3'b011);
        check("op3_exec_valid", out_valid, 0);
        next_cycle();
        @(negedge clk);                                   // N+2
        check("op3_out_valid", out_valid, 1);
        check("op3_out_err",   out_err, 0);
        check("op3_out_z",     out_z, 32'd5);
        check("op3_out_id",    out_id, 1);
        next_cycle();
`endif

        // ---------------- randomized traffic vs. reference model ----------------
        do_reset();
        m_inflight = 1'b0; m_age = 0; m_last = 1'b1;
        m_z = '0; m_ex = 1'b0; m_id = 1'b0;
        pend0 = 1'b0; pend1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic [2:0] ops[4];
            logic       g_valid, g_id, exp_valid;
            ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110;
            // Requesters hold a pending request until it is accepted.
            if (!pend0 && ($urandom_range(0, 1) == 1)) begin
                pend0 = 1'b1; in0_a = $urandom; in0_b = $urandom; in0_op = ops[$urandom_range(0, 3)];
            end
            if (!pend1 && ($urandom_range(0, 1) == 1)) begin
                pend1 = 1'b1; in1_a = $urandom; in1_b = $urandom; in1_op = ops[$urandom_range(0, 3)];
            end
            in0_valid = pend0;
            in1_valid = pend1;
            out_ready = ($urandom_range(0, 3) != 0);

            @(negedge clk);
            g_valid   = !m_inflight && (pend0 || pend1);
            g_id      = (pend0 && pend1) ? ~m_last : pend1;
            exp_valid = m_inflight && (m_age >= 1);
            check("rnd_in0_ready", in0_ready, g_valid && !g_id);
            check("rnd_in1_ready", in1_ready, g_valid && g_id);
            check("rnd_out_valid", out_valid, exp_valid);
            check("rnd_busy",      busy, m_inflight);
            if (exp_valid) begin
                check("rnd_out_z",  out_z, m_z);
                check("rnd_out_ex", out_ex, m_ex);
                check("rnd_out_id", out_id, m_id);
            end

            if (m_inflight) begin
                if (exp_valid && out_ready) begin
                    m_inflight = 1'b0;
                    m_last     = m_id;
                end else begin
                    m_age++;
                end
            end else if (g_valid) begin
                m_inflight = 1'b1;
                m_age      = 0;
                m_id       = g_id;
                if (g_id) begin
                    ref_alu(in1_a, in1_b, in1_op, m_z, m_ex);
                    pend1 = 1'b0;
                end else begin
                    ref_alu(in0_a, in0_b, in0_op, m_z, m_ex);
                    pend0 = 1'b0;
                end
            end
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand/result width.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 in0_valid, in1_valid  input  1 each  SHALL be the requester operation requests.
REQ-005 in0_a, in0_b, in1_a, in1_b  input  WIDTH each  SHALL be the requester operands.
REQ-006 in0_op, in1_op  input  3 each  SHALL be the ALU opcodes: 000 AND, 001 OR, 010 ADD, 110 SUB.
REQ-007 in0_ready, in1_ready  output  1 each  SHALL be the grant/accept strobes.
REQ-008 alu_a, alu_b  output  WIDTH each; alu_op  output  3  SHALL drive the shared combinational ALU.
REQ-009 alu_z  input  WIDTH; alu_ex  input  1  SHALL be the ALU result and flag.
REQ-010 out_valid  output  1; out_ready  input  1  SHALL be the result handshake.
REQ-011 out_z  output  WIDTH; out_ex  output  1; out_id  output  1; out_err  output  1  SHALL be the result, flag, requester index and illegal-op flag.
REQ-012 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-014 IDLE: if no valid is high, remain in IDLE; inN_ready = 0.
REQ-015 IDLE with exactly one valid: that requester's ready = 1 (combinational); its a, b, op and index are latched into the operand registers; next state is EXEC.
REQ-016 IDLE with both valid: grant the requester != last_grant (round-robin); the other's ready = 0.
REQ-017 inN_ready SHALL be 0 in EXEC and RESP; a transfer occurs only when valid and ready are both high in the same cycle.
REQ-018 Requesters SHALL hold valid and operands until ready; valid dropped before ready SHALL cause no grant and no state change.
REQ-019 alu_a/alu_b/alu_op SHALL always equal the operand registers, stable from EXEC through RESP.
REQ-020 EXEC: alu_z and alu_ex are captured into out_z/out_ex; out_id takes the latched index; next state is RESP.
REQ-021 RESP: out_valid = 1 with out_z/out_ex/out_id/out_err held constant until out_ready = 1; on out_ready go to IDLE and set last_grant = out_id.
REQ-022 out_valid SHALL be 0 in IDLE and EXEC.
REQ-023 Latency: accept in cycle N, out_valid in cycle N+2; minimum issue interval 3 cycles.
REQ-024 New requests arriving during EXEC/RESP SHALL wait; no request is ever dropped once accepted.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH, unchanged from the ALU; the block SHALL not modify alu_z.

Reset
REQ-026 Reset SHALL force IDLE, out_valid = 0, out_z = 0, out_ex = 0, out_id = 0, out_err = 0, busy = 0, both ready = 0, operand registers = 0, and last_grant = 1 so that requester 0 wins the first tie.
REQ-027 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response emitted.

Configuration
REQ-028 Macro ALU_OPCHECK_EN defined: an accepted op outside {000, 001, 010, 110} SHALL skip EXEC, go directly to RESP with out_err = 1, out_z = 0, out_ex = 0, correct out_id, latency N+1.
REQ-029 ALU_OPCHECK_EN undefined: every op SHALL be passed through to the ALU unchecked; out_err SHALL be tied 0.

Verification
REQ-030 Single request: in0 a=5, b=3, op=010, out_ready=1 -> in0_ready in cycle N; out_valid in N+2 with out_z=8, out_id=0.
REQ-031 Tie: both valid in IDLE after reset, in0 op=000, in1 op=110 with a=3, b=5 -> in0 served first; in1 next, out_z=32'hFFFFFFFE, out_id=1.
REQ-032 Fairness: both valid continuously for 6 operations -> out_id sequence 0,1,0,1,0,1.
REQ-033 Backpressure: out_ready=0 for 5 cycles in RESP -> out_valid and out_z held constant, inN_ready=0, busy=1; completion on the cycle out_ready=1.
REQ-034 Reset during EXEC -> next cycle out_valid=0, busy=0, state IDLE; no result appears.
REQ-035 With ALU_OPCHECK_EN: in1 op=011 -> out_err=1, out_z=0, out_id=1 at N+1; without the macro: alu_op=011 is driven, out_err=0.
